// File: rtl/pla_eval_sequencer.sv
// Exhaustive-vector fitness sequencer: sweeps every input vector through candidate and golden netlists
// and accumulates the masked, saturating Hamming distance. Optional early abort: PLA_EVAL_EARLY_ABORT_EN.
module pla_eval_sequencer #(
  parameter int unsigned N_IN   = 12,
  parameter int unsigned N_OUT  = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] out_mask,
  input  logic [ERR_W-1:0] abort_limit,
  output logic [N_IN-1:0]  dut_pi,
  input  logic [N_OUT-1:0] cand_po,
  input  logic [N_OUT-1:0] gold_po,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int unsigned POP_W       = $clog2(N_OUT + 1);
  localparam int unsigned SUM_W       = ERR_W + POP_W;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE, S_DONE} state_t;

  // With SETTLE=0 every vector is compared on the cycle it is driven
  localparam state_t FIRST = (SETTLE > 0) ? S_SETTLE : S_COMPARE;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  pi_q, pi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N_OUT-1:0] mask_q, mask_d;
  logic [ERR_W-1:0] limit_q, limit_d;

  logic [N_OUT-1:0] diff;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [ERR_W-1:0] err_add;
  logic             abort_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pi_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= '0;
      mask_q    <= '0;
      limit_q   <= '0;
    end else begin
      state_q   <= state_d;
      pi_q      <= pi_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      limit_q   <= limit_d;
    end
  end

  // Masked popcount with saturating accumulate
  always_comb begin
    diff = (cand_po ^ gold_po) & mask_q;
    pop  = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      pop = pop + POP_W'(diff[i]);
    end
    sum     = SUM_W'(err_q) + SUM_W'(pop);
    err_add = (sum > SUM_W'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
  end

`ifdef PLA_EVAL_EARLY_ABORT_EN
  assign abort_hit = (limit_q != '0) && (err_add >= limit_q);
`else
  logic unused_limit;
  assign unused_limit = ^limit_q;
  assign abort_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pi_d      = pi_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    err_d     = err_q;
    mask_d    = mask_q;
    limit_d   = limit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pi_d      = '0;
          cnt_d     = '0;
          err_d     = '0;
          aborted_d = 1'b0;
          busy_d    = 1'b1;
          mask_d    = out_mask;
          limit_d   = abort_limit;
          state_d   = FIRST;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_LAST)) begin
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMPARE: begin
        err_d = err_add;
        cnt_d = '0;
        if (abort_hit || (pi_q == '1)) begin
          aborted_d = abort_hit;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          pi_d    = pi_q + N_IN'(1);
          state_d = FIRST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dut_pi    = pi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_pla_eval_sequencer.sv
// Bench for pla_eval_sequencer: table of full runs plus hand sequences for abort, reset and SETTLE variants.
module tb_pla_eval_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0;
  logic        start_6 = 1'b0;
  logic [7:0]  mask = 8'hFF;
  logic [7:0]  pat = 8'h00;
  logic [15:0] limit = 16'd0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [11:0] pi_m, pi_e8, pi_s0, pi_s3;
  logic [7:0]  gold_m, gold_e8, gold_s0, gold_s3;
  logic [7:0]  cand_m, cand_e8, cand_s0, cand_s3;
  logic        busy_m, done_m, ab_m, busy_e8, done_e8, ab_e8;
  logic        busy_s0, done_s0, ab_s0, busy_s3, done_s3, ab_s3;
  logic [15:0] err_m, err_s0, err_s3;
  logic [7:0]  err_e8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gold_f(input logic [11:0] x);
    return x[7:0] ^ {x[11:8], x[3:0]} ^ 8'h5A;
  endfunction

  assign gold_m  = gold_f(pi_m);
  assign gold_e8 = gold_f(pi_e8);
  assign gold_s0 = gold_f(pi_s0);
  assign gold_s3 = gold_f(pi_s3);
  assign cand_m  = gold_m ^ pat;
  assign cand_e8 = gold_e8 ^ pat;
  assign cand_s0 = gold_s0 ^ pat;
  assign cand_s3 = gold_s3 ^ pat;

  pla_eval_sequencer u_m (
    .clk(clk), .rst(rst), .start(start_m), .out_mask(mask), .abort_limit(limit),
    .dut_pi(pi_m), .cand_po(cand_m), .gold_po(gold_m),
    .busy(busy_m), .done(done_m), .aborted(ab_m), .err_count(err_m));

  pla_eval_sequencer #(.ERR_W(8)) u_e8 (
    .clk(clk), .rst(rst), .start(start_m), .out_mask(mask), .abort_limit(limit[7:0]),
    .dut_pi(pi_e8), .cand_po(cand_e8), .gold_po(gold_e8),
    .busy(busy_e8), .done(done_e8), .aborted(ab_e8), .err_count(err_e8));

  pla_eval_sequencer #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_6), .out_mask(mask), .abort_limit(16'd0),
    .dut_pi(pi_s0), .cand_po(cand_s0), .gold_po(gold_s0),
    .busy(busy_s0), .done(done_s0), .aborted(ab_s0), .err_count(err_s0));

  pla_eval_sequencer #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start_6), .out_mask(mask), .abort_limit(16'd0),
    .dut_pi(pi_s3), .cand_po(cand_s3), .gold_po(gold_s3),
    .busy(busy_s3), .done(done_s3), .aborted(ab_s3), .err_count(err_s3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start u_m and u_e8 together; return done latency of each relative to the start edge
  task automatic run_main(output int cyc_m, output int cyc_e8);
    int  t0;
    bit  dm;
    bit  de;
    cyc_m  = -1;
    cyc_e8 = -1;
    dm     = 1'b0;
    de     = 1'b0;
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    t0 = cyc;
    check("busy_after_start", 32'(busy_m), 32'd1);
    for (int i = 0; i < 20000 && !dm; i++) begin
      @(negedge clk);
      if (done_e8 && !de) begin
        de     = 1'b1;
        cyc_e8 = cyc - t0;
      end
      if (done_m) begin
        dm    = 1'b1;
        cyc_m = cyc - t0;
      end
    end
    if (!dm) check("timeout_main", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  pat;
    logic [15:0] exp_err;
    logic [7:0]  exp_err8;
    int          exp_cyc;
  } vec_t;

  vec_t tbl [4];

`ifdef PLA_EVAL_EARLY_ABORT_EN
  localparam int          AB_CYC = 200;
  localparam logic [15:0] AB_ERR = 16'd100;
  localparam logic [11:0] AB_PI  = 12'h063;
  localparam logic        AB_FLG = 1'b1;
`else
  localparam int          AB_CYC = 8192;
  localparam logic [15:0] AB_ERR = 16'd4096;
  localparam logic [11:0] AB_PI  = 12'hFFF;
  localparam logic        AB_FLG = 1'b0;
`endif

  initial begin
    int cm;
    int ce;
    int t0;
    int c0;
    int c3;
    bit hit;

    tbl[0] = '{8'hFF, 8'h00, 16'd0,     8'd0,   8192};
    tbl[1] = '{8'hFF, 8'h01, 16'd4096,  8'd255, 8192};
    tbl[2] = '{8'hFE, 8'h01, 16'd0,     8'd0,   8192};
    tbl[3] = '{8'hFF, 8'hFF, 16'd32768, 8'd255, 8192};

    #23;
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_aborted", 32'(ab_m), 32'd0);
    check("rst_err", 32'(err_m), 32'd0);
    check("rst_pi", 32'(pi_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      mask = tbl[r].mask;
      pat  = tbl[r].pat;
      run_main(cm, ce);
      check($sformatf("row%0d_cycles", r), 32'(cm), 32'(tbl[r].exp_cyc));
      check($sformatf("row%0d_err", r), 32'(err_m), 32'(tbl[r].exp_err));
      check($sformatf("row%0d_aborted", r), 32'(ab_m), 32'd0);
      check($sformatf("row%0d_busy_at_done", r), 32'(busy_m), 32'd0);
      check($sformatf("row%0d_pi_end", r), 32'(pi_m), 32'hFFF);
      check($sformatf("row%0d_e8_cycles", r), 32'(ce), 32'(tbl[r].exp_cyc));
      check($sformatf("row%0d_e8_err", r), 32'(err_e8), 32'(tbl[r].exp_err8));
    end

    // Early abort (or full run without the feature); start during DONE must be ignored
    mask  = 8'hFF;
    pat   = 8'h01;
    limit = 16'd100;
    run_main(cm, ce);
    check("abort_cycles", 32'(cm), 32'(AB_CYC));
    check("abort_err", 32'(err_m), 32'(AB_ERR));
    check("abort_pi", 32'(pi_m), 32'(AB_PI));
    check("abort_flag", 32'(ab_m), 32'(AB_FLG));
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    check("done_one_cycle", 32'(done_m), 32'd0);
    check("start_in_done_ignored", 32'(busy_m), 32'd0);
    check("aborted_held", 32'(ab_m), 32'(AB_FLG));
    check("err_held", 32'(err_m), 32'(AB_ERR));
    check("pi_held", 32'(pi_m), 32'(AB_PI));
    limit = 16'd0;

    // Reset mid-run, with start pulses while busy
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (7) @(negedge clk);
    start_m = 1'b1;
    repeat (3) @(negedge clk);
    start_m = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (pi_m == 12'h200) hit = 1'b1;
    end
    check("reach_200", 32'(hit), 32'd1);
    check("err_at_200", 32'(err_m), 32'd512);
    check("busy_at_200", 32'(busy_m), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_m), 32'd0);
    check("midrst_pi", 32'(pi_m), 32'd0);
    check("midrst_err", 32'(err_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(busy_m), 32'd0);

    // SETTLE=0 and SETTLE=3 in parallel
    mask = 8'hFF;
    pat  = 8'h80;
    @(negedge clk);
    start_6 = 1'b1;
    @(negedge clk);
    start_6 = 1'b0;
    t0 = cyc;
    c0 = -1;
    c3 = -1;
    for (int i = 0; i < 20000 && c3 < 0; i++) begin
      @(negedge clk);
      if (done_s0 && c0 < 0) begin
        c0 = cyc - t0;
        check("s0_err", 32'(err_s0), 32'd4096);
      end
      if (done_s3) begin
        c3 = cyc - t0;
        check("s3_err", 32'(err_s3), 32'd4096);
      end
    end
    check("s0_cycles", 32'(c0), 32'd4096);
    check("s3_cycles", 32'(c3), 32'd16384);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
